fpu_result_collector: RTL

//  Downstream of the FPU top controller: consumes its split 16-bit result stream (upper half, then

---
 rtl/fpu_rescol_pkg.sv | 17 +
 rtl/fpu_result_collector_if.sv | 42 ++++
 rtl/fpu_res_fifo.sv | 65 ++++++
 rtl/fpu_result_collector.sv | 120 ++++++++++++
 4 files changed

// File: rtl/fpu_rescol_pkg.sv
// Shared types for the FPU result collector: collector FSM states and the reassembled FIFO entry.
package fpu_rescol_pkg;

  localparam int unsigned HALF_W = 16;
  localparam int unsigned EXC_W  = 3;

  typedef enum logic {
    COL_HI = 1'b0,
    COL_LO = 1'b1
  } col_state_t;

  typedef struct packed {
    logic [2*HALF_W-1:0] data;
    logic [EXC_W-1:0]    exc;
  } fpu_res_t;

endpackage

// File: rtl/fpu_result_collector_if.sv
// Bundle of FPU-side, consumer-side and status signals for fpu_result_collector.
// Statistics signals exist only when FPU_RESCOL_STATS_EN is defined.
interface fpu_result_collector_if #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
);
  localparam int unsigned LvlW = $clog2(FIFO_DEPTH) + 1;

  logic [15:0]     FPU_DOUT;
  logic            FPU_DOV;
  logic [2:0]      FPU_EXC;
  logic            FPU_DOA;
  logic [31:0]     RES_DATA;
  logic [2:0]      RES_EXC;
  logic            RES_VALID;
  logic            RES_READY;
  logic [LvlW-1:0] FIFO_LEVEL;
  logic            PROTO_ERR;
`ifdef FPU_RESCOL_STATS_EN
  logic [CNT_W-1:0] RES_CNT;
  logic [CNT_W-1:0] EXC_CNT;

  modport slave (
    input  FPU_DOUT, FPU_DOV, FPU_EXC, RES_READY,
    output FPU_DOA, RES_DATA, RES_EXC, RES_VALID, FIFO_LEVEL, PROTO_ERR, RES_CNT, EXC_CNT
  );
  modport master (
    output FPU_DOUT, FPU_DOV, FPU_EXC, RES_READY,
    input  FPU_DOA, RES_DATA, RES_EXC, RES_VALID, FIFO_LEVEL, PROTO_ERR, RES_CNT, EXC_CNT
  );
`else
  modport slave (
    input  FPU_DOUT, FPU_DOV, FPU_EXC, RES_READY,
    output FPU_DOA, RES_DATA, RES_EXC, RES_VALID, FIFO_LEVEL, PROTO_ERR
  );
  modport master (
    output FPU_DOUT, FPU_DOV, FPU_EXC, RES_READY,
    input  FPU_DOA, RES_DATA, RES_EXC, RES_VALID, FIFO_LEVEL, PROTO_ERR
  );
`endif

endinterface

// File: rtl/fpu_res_fifo.sv
// Power-of-two depth FIFO of reassembled FPU results; synchronous active-low reset,
// no bypass, push when full and pop when empty are ignored.
module fpu_res_fifo
  import fpu_rescol_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  fpu_res_t                 data_i,
  input  logic                     pop_i,
  output fpu_res_t                 data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  fpu_res_t        mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [AW:0]     level_q, level_d;
  logic            push_en, pop_en;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    // Pointers wrap naturally because DEPTH is a power of two.
    if (push_en) wptr_d = wptr_q + AW'(1);
    if (pop_en)  rptr_d = rptr_q + AW'(1);
    unique case ({push_en, pop_en})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wptr_q] <= data_i;
  end

  assign data_o  = mem_q[rptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/fpu_result_collector.sv
// Reassembles the FPU's split upper/lower result stream into 32-bit results and queues them.
// Define FPU_RESCOL_STATS_EN to add saturating push / exception-push counters.
module fpu_result_collector
  import fpu_rescol_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  fpu_result_collector_if.slave  bus
);

  col_state_t        state_q, state_d;
  logic [HALF_W-1:0] hi_q, hi_d;
  logic [EXC_W-1:0]  exc_q, exc_d;
  logic              proto_err_q, proto_err_d;
  logic              push, pop, full, empty, doa;
  fpu_res_t          push_data, head;

  // DOA depends only on registered state and level so the FPU never sees a path from RES_READY.
  assign doa = (state_q == COL_LO) & ~full;

  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    exc_d       = exc_q;
    proto_err_d = proto_err_q;
    push        = 1'b0;
    unique case (state_q)
      COL_HI: begin
        if (bus.FPU_DOV) begin
          hi_d    = bus.FPU_DOUT;
          exc_d   = bus.FPU_EXC;
          state_d = COL_LO;
        end
      end
      COL_LO: begin
        if (!bus.FPU_DOV) begin
          proto_err_d = 1'b1;
          state_d     = COL_HI;
        end else begin
          if (bus.FPU_EXC != exc_q) proto_err_d = 1'b1;
          if (doa) begin
            push    = 1'b1;
            state_d = COL_HI;
          end
        end
      end
      default: state_d = COL_HI;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q     <= COL_HI;
      hi_q        <= '0;
      exc_q       <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      exc_q       <= exc_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign push_data.data = {hi_q, bus.FPU_DOUT};
  assign push_data.exc  = exc_q;
  assign pop            = bus.RES_READY & ~empty;

  fpu_res_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RSTn),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (bus.FIFO_LEVEL)
  );

  assign bus.FPU_DOA   = doa;
  assign bus.RES_DATA  = head.data;
  assign bus.RES_EXC   = head.exc;
  assign bus.RES_VALID = ~empty;
  assign bus.PROTO_ERR = proto_err_q;

`ifdef FPU_RESCOL_STATS_EN
  logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
  logic [CNT_W-1:0] exc_cnt_q, exc_cnt_d;

  always_comb begin
    res_cnt_d = res_cnt_q;
    exc_cnt_d = exc_cnt_q;
    if (push && !(&res_cnt_q)) res_cnt_d = res_cnt_q + CNT_W'(1);
    if (push && (exc_q != '0) && !(&exc_cnt_q)) exc_cnt_d = exc_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      res_cnt_q <= '0;
      exc_cnt_q <= '0;
    end else begin
      res_cnt_q <= res_cnt_d;
      exc_cnt_q <= exc_cnt_d;
    end
  end

  assign bus.RES_CNT = res_cnt_q;
  assign bus.EXC_CNT = exc_cnt_q;
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule
